// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    // Default divider / meter constants
    localparam int DEF_CNT_W    = 32;
    localparam int DEF_EXP_HALF = 100000;
    localparam int DEF_TOL      = 0;
    localparam int DEF_LOCK_N   = 4;
    localparam int DEF_TIMEOUT  = 1000000;

    // Full period of a divider given its half-period
    function automatic longint exp_period(input longint half);
        return 2 * half;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for the slow clock plus a delay flop for edge detection.
module sync_edge
    import clk_meter_pkg::*;
(
    input  logic I_CLK,
    input  logic rst,
    input  logic S_CLK,
    output logic s_lvl,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Bring S_CLK into the I_CLK domain and keep one extra sample for edges
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= S_CLK;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign s_lvl = r_s2;
    assign rise  = r_s2 & ~r_s3;
    assign fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock in I_CLK cycles, with lock and timeout.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EXP_HALF = DEF_EXP_HALF,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_N   = DEF_LOCK_N,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic             en,
    input  logic             S_CLK,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             lock_o,
    output logic             timeout_o
);

    // Tolerance window evaluated one bit wider than the counters so it cannot wrap
    localparam longint EXP_P = exp_period(longint'(EXP_HALF));
    localparam longint LO_L  = (EXP_P > longint'(TOL)) ? EXP_P - longint'(TOL) : 64'sd0;
    localparam longint HI_L  = EXP_P + longint'(TOL);
    localparam logic [CNT_W:0] P_LO = LO_L[CNT_W:0];
    localparam logic [CNT_W:0] P_HI = HI_L[CNT_W:0];

    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_N);
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    function automatic logic f_in_tol(input logic [CNT_W-1:0] p);
        logic [CNT_W:0] w_p;
        w_p = {1'b0, p};
        return (w_p >= P_LO) && (w_p <= P_HI);
    endfunction

    function automatic logic [MW-1:0] f_sat_inc(input logic [MW-1:0] m);
        return (m >= LOCK_M) ? LOCK_M : m + MW'(1);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_s_lvl;
    logic             w_rise;
    logic             w_fall;
    logic             r_s_lvl_p0;
    logic             r_rise_p0;
    logic             r_fall_p0;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_start;
    logic             w_meas_rise;
    logic             w_tmo;
    logic             r_vld_p1;
    logic [MW-1:0]    r_match;
    logic [MW-1:0]    w_match_nxt;

    sync_edge u_sync_edge (
        .I_CLK (I_CLK),
        .rst   (rst),
        .S_CLK (S_CLK),
        .s_lvl (w_s_lvl),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_cnt_inc = r_cnt + ONE_C;

    // ---- stage p0: registered edge events and level ----
    // Register edges so valid_o lands four cycles after S_CLK is first sampled high
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            r_s_lvl_p0 <= 1'b0;
            r_rise_p0  <= 1'b0;
            r_fall_p0  <= 1'b0;
        end else begin
            r_s_lvl_p0 <= w_s_lvl;
            r_rise_p0  <= w_rise;
            r_fall_p0  <= w_fall;
        end
    end

    // FSM state register
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle decisions; a rise always beats a timeout
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_meas_rise = 1'b0;
        w_tmo       = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = ARM;
                ARM: begin
                    if (r_rise_p0) begin
                        w_start     = 1'b1;
                        w_state_nxt = MEAS;
                    end else if (w_cnt_inc >= TO_C) begin
                        w_tmo = 1'b1;
                    end
                end
                MEAS: begin
                    if (r_rise_p0) begin
                        w_meas_rise = 1'b1;
                    end else if (w_cnt_inc >= TO_C) begin
                        w_tmo       = 1'b1;
                        w_state_nxt = ARM;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Period and high-time counters; cnt doubles as the ARM wait timer
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (!en || (r_state == IDLE) || w_tmo) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_start || w_meas_rise) begin
            r_cnt  <= ONE_C;
            r_hcnt <= ONE_C;
        end else begin
            r_cnt <= w_cnt_inc;
            if ((r_state == MEAS) && r_s_lvl_p0) begin
                r_hcnt <= r_hcnt + ONE_C;
            end
        end
    end

    // ---- stage p1: capture measurements ----
    // Latch period on rise and high time on fall while measuring
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            period_o <= '0;
            high_o   <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_meas_rise;
            if (w_meas_rise) begin
                period_o <= r_cnt;
            end
            if (en && (r_state == MEAS) && r_fall_p0) begin
                high_o <= r_hcnt;
            end
        end
    end

    always_comb begin
        w_match_nxt = f_in_tol(period_o) ? f_sat_inc(r_match) : '0;
    end

    // ---- stage p2: valid pulse, lock tracking, timeout flag ----
    // Lock and timeout change on the same edge that raises valid_o
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            valid_o   <= 1'b0;
            lock_o    <= 1'b0;
            timeout_o <= 1'b0;
            r_match   <= '0;
        end else begin
            valid_o <= r_vld_p1;
            if (w_tmo) begin
                timeout_o <= 1'b1;
                lock_o    <= 1'b0;
                r_match   <= '0;
            end else begin
                if (r_vld_p1) begin
                    timeout_o <= 1'b0;
                end
                if (!en) begin
                    lock_o  <= 1'b0;
                    r_match <= '0;
                end else if (r_vld_p1) begin
                    r_match <= w_match_nxt;
                    lock_o  <= (w_match_nxt >= LOCK_M);
                end
            end
        end
    end

endmodule
